// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-port bundle between the 8-bit byte FIFO and its UART drain stage.
//
// Signals
//   fifo_empty  FIFO empty flag, combinational from the FIFO pointers
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  pop strobe, single-cycle pulse from the drain stage
//
// Modports
//   master  the drain stage (drives the pop strobe, consumes flag and data)
//   slave   the FIFO side (answers the pop strobe with flag and data)
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drain stage for the 16-deep byte FIFO. Pops one byte at a time through the
// FIFO read port and serialises it onto a UART line, 8N1, LSB first.
//
// Optional feature: define PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit (frame becomes 11 bits). With the macro
// undefined there is no parity state and no parity logic.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   CNT_W         baud counter width, 2**CNT_W > CLKS_PER_BIT
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous reset, active low
//   en       in   1 = new frames may start; 0 = finish current frame, then hold
//   fifo     if   FIFO read port (master side: drives fifo_rd_en)
//   tx       out  serial line, idles high
//   busy     out  high from FETCH through the end of STOP
//   tx_done  out  one-cycle pulse on the last clk of each STOP bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // tx_done is registered, so it is scheduled one clk before the last STOP clk.
  localparam logic [CNT_W-1:0] BIT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
`ifdef PARITY_EN
  logic             parity_acc;
`endif

  logic bit_end;

  assign bit_end = (baud_cnt == BIT_LAST);

  // Single state machine with registered outputs. tx is always loaded with
  // the value of the bit that starts on the next clk, so the line changes
  // exactly on bit boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      baud_cnt        <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
`ifdef PARITY_EN
      parity_acc      <= 1'b0;
`endif
      fifo.fifo_rd_en <= 1'b0;
      tx              <= 1'b1;
      busy            <= 1'b0;
      tx_done         <= 1'b0;
    end else begin
      fifo.fifo_rd_en <= 1'b0;
      tx_done         <= 1'b0;

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          // en is only looked at here, so dropping it mid-frame lets the
          // current frame run to completion.
          if (en && !fifo.fifo_empty) begin
            state           <= FETCH;
            fifo.fifo_rd_en <= 1'b1;
            busy            <= 1'b1;
          end
        end

        FETCH: begin
          state <= LOAD;
        end

        LOAD: begin
          shift_reg  <= fifo.fifo_dout;
`ifdef PARITY_EN
          parity_acc <= 1'b0;
`endif
          baud_cnt   <= '0;
          tx         <= 1'b0;
          state      <= START;
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
`ifdef PARITY_EN
            parity_acc <= parity_acc ^ shift_reg[0];
`endif
            if (bit_cnt == 3'd7) begin
`ifdef PARITY_EN
              // Fold in the bit just finished so the parity bit covers all 8.
              tx    <= parity_acc ^ shift_reg[0];
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
            if (baud_cnt == BIT_PRE_LAST) begin
              tx_done <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT = 4. A queue-based
// FIFO model feeds the DUT, a line monitor decodes whole frames off tx, and
// each decoded frame is compared with the frame built from the pushed byte.
// Define PARITY_EN for both the RTL and this bench to exercise parity.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  typedef struct {
    logic [10:0] bits;
    int          done_off;
    int          lat;
    bit          glitch;
  } frame_t;

  logic clk;
  logic rst_n;
  logic en;
  logic tx;
  logic busy;
  logic tx_done;

  logic       wr_en;
  logic [7:0] wr_data;

  fifo_uart_tx_if ifc ();

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .fifo   (ifc),
    .tx     (tx),
    .busy   (busy),
    .tx_done(tx_done)
  );

  int errors = 0;
  int checks = 0;

  // Clock: 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish expected finish by 300000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Upstream FIFO model: push from the stimulus, pop on fifo_rd_en
  logic [7:0] mem[$];
  int         fifo_count = 0;

  assign ifc.fifo_empty = (fifo_count == 0);

  initial ifc.fifo_dout = 8'h00;

  always @(posedge clk) begin
    if (ifc.fifo_rd_en && fifo_count > 0) ifc.fifo_dout <= mem.pop_front();
    if (wr_en) mem.push_back(wr_data);
    fifo_count <= mem.size();
  end

  // Line monitor: counters plus a frame decoder working on whole bit periods
  int     cyc         = 0;
  int     pop_cnt     = 0;
  int     pop_empty   = 0;
  int     rd_long     = 0;
  int     done_cnt    = 0;
  int     tx_low_cnt  = 0;
  int     last_rd_cyc = 0;
  bit     prev_rd     = 0;
  bit     had_busy    = 0;
  int     low_run     = 0;
  int     gap_q[$];
  frame_t got_q[$];

  bit     in_frame = 0;
  int     pos      = 0;
  logic   cur_bit  = 1'b1;
  frame_t rec;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 0;
      had_busy = 0;
      low_run  = 0;
      prev_rd  = 0;
    end else begin
      if (ifc.fifo_rd_en) begin
        pop_cnt++;
        last_rd_cyc = cyc;
        if (prev_rd) rd_long++;
        if (fifo_count == 0) pop_empty++;
      end
      prev_rd = ifc.fifo_rd_en;
      if (tx_done) done_cnt++;
      if (!tx) tx_low_cnt++;

      if (busy) begin
        if (had_busy && low_run > 0) gap_q.push_back(low_run);
        had_busy = 1;
        low_run  = 0;
      end else begin
        low_run++;
      end

      if (!in_frame && !tx) begin
        in_frame     = 1;
        pos          = 0;
        rec.bits     = '0;
        rec.done_off = -1;
        rec.lat      = cyc - last_rd_cyc;
        rec.glitch   = 0;
      end
      if (in_frame) begin
        if (pos % CPB == 0) begin
          cur_bit = tx;
          rec.bits[pos / CPB] = tx;
        end else if (tx !== cur_bit) begin
          rec.glitch = 1;
        end
        if (tx_done) rec.done_off = pos + 1;
        pos++;
        if (pos == FB * CPB) begin
          in_frame = 0;
          got_q.push_back(rec);
        end
      end
    end
  end

  // Reference frame: start bit, data LSB first, optional even parity, stop
  function automatic logic [10:0] frameOf(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f    = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i + 1] = b[i];
      ones += int'(b[i]);
    end
`ifdef PARITY_EN
    f[9]  = (ones % 2 == 1);
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] exp_q[$];
  int         got_idx = 0;

  // Push one byte into the FIFO model and record it for the scoreboard
  task automatic applyStimulus(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, done_cnt, target);
  endtask

  task automatic waitPops(input int target, input int budget, input string tag);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, pop_cnt, target);
  endtask

  // Compare every newly decoded frame against the byte pushed in that order
  task automatic checkFrames();
    logic [7:0] b;
    while (got_idx < got_q.size()) begin
      if (exp_q.size() == 0) begin
        checkOutput("frame_unexpected", 1, 0);
      end else begin
        b = exp_q.pop_front();
        checkOutput("frame_bits", 32'(got_q[got_idx].bits), 32'(frameOf(b)));
        checkOutput("frame_glitch", 32'(got_q[got_idx].glitch), 0);
        checkOutput("frame_done_pos", got_q[got_idx].done_off, FB * CPB);
        checkOutput("frame_latency", got_q[got_idx].lat, 2);
      end
      got_idx++;
    end
  endtask

  initial begin
    int g;
    int frames_before;

    rst_n   = 1'b0;
    en      = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) tick();

    $display("[TB] reset values");
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_en", ifc.fifo_rd_en, 0);
    checkOutput("rst_tx_done", tx_done, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] enabled with empty FIFO");
    en = 1'b1;
    repeat (100) tick();
    checkOutput("empty_pops", pop_cnt, 0);
    checkOutput("empty_tx_low", tx_low_cnt, 0);
    checkOutput("empty_busy", busy, 0);

    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5);
    waitDone(1, 200, "a5_done");
    repeat (5) tick();
    checkOutput("a5_pops", pop_cnt, 1);
    checkOutput("a5_frames", got_q.size(), 1);
    checkFrames();

    $display("[TB] back-to-back 0x01, 0x80");
    applyStimulus(8'h01);
    applyStimulus(8'h80);
    waitDone(3, 400, "b2b_done");
    repeat (5) tick();
    checkOutput("b2b_pops", pop_cnt, 3);
    g = (gap_q.size() > 0) ? gap_q[$] : -1;
    checkOutput("b2b_gap", g, 1);
    checkFrames();

    $display("[TB] enable dropped mid-frame with 3 bytes queued");
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    applyStimulus(8'($urandom));
    waitPops(4, 50, "en_drop_first_pop");
    repeat (10) tick();
    en = 1'b0;
    waitDone(4, 200, "en_drop_done");
    repeat (30) tick();
    checkOutput("en_drop_pops", pop_cnt, 4);
    checkOutput("en_drop_busy", busy, 0);
    checkOutput("en_drop_fifo_left", fifo_count, 2);
    checkFrames();
    en = 1'b1;
    waitDone(6, 400, "en_resume_done");
    repeat (5) tick();
    checkFrames();

    $display("[TB] random bytes with random spacing");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'($urandom));
      repeat ($urandom_range(0, 40)) tick();
    end
    waitDone(12, 1000, "rand_done");
    repeat (5) tick();
    checkOutput("rand_pops", pop_cnt, 12);
    checkFrames();
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] reset asserted mid-STOP");
    applyStimulus(8'h5A);
    waitPops(13, 50, "rst_frame_pop");
    repeat ((FB - 1) * CPB + 2) tick();
    checkOutput("pre_rst_tx_stop", tx, 1);
    checkOutput("pre_rst_busy", busy, 1);
    frames_before = got_q.size();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_tx", tx, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rd_en", ifc.fifo_rd_en, 0);
    checkOutput("midrst_tx_done", tx_done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_hold_tx", tx, 1);
      checkOutput("rst_hold_busy", busy, 0);
      checkOutput("rst_hold_rd_en", ifc.fifo_rd_en, 0);
      checkOutput("rst_hold_tx_done", tx_done, 0);
    end
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    repeat (20) tick();
    checkOutput("rst_lost_frame", got_q.size(), frames_before);
    checkOutput("rst_no_done", done_cnt, 12);
    checkOutput("rst_no_pop", pop_cnt, 13);
    checkOutput("rst_idle_tx", tx, 1);

    checkOutput("pop_while_empty", pop_empty, 0);
    checkOutput("rd_en_pulse_len", rd_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
